// File: rtl/int_manager_if.sv
// int_manager_if: groups the CPU / interrupt-controller signals seen by
// int_manager.
//   slave  : int_manager side (requests and strobes in, control out)
//   master : CPU / controller side (drives requests, observes control)
interface int_manager_if #(
  parameter int VEC_W = 16
);
  logic             manager_irq;
  logic [VEC_W-1:0] int_addr;
  logic             instr_boundary;
  logic [VEC_W-1:0] pc_in;
  logic             rti;
  logic             epc_wr;
  logic [VEC_W-1:0] epc_wdata;
  logic             priv_lv;
  logic             cpu_stall;
  logic             pc_load;
  logic [VEC_W-1:0] pc_load_addr;
  logic [VEC_W-1:0] epc;
  logic [VEC_W-1:0] last_vec;
  logic             priv_fault;

  modport slave (
    input  manager_irq, int_addr, instr_boundary, pc_in, rti, epc_wr, epc_wdata,
    output priv_lv, cpu_stall, pc_load, pc_load_addr, epc, last_vec, priv_fault
  );

  modport master (
    output manager_irq, int_addr, instr_boundary, pc_in, rti, epc_wr, epc_wdata,
    input  priv_lv, cpu_stall, pc_load, pc_load_addr, epc, last_vec, priv_fault
  );
endinterface

// File: rtl/int_manager.sv
// int_manager: CPU-side interrupt responder. Takes the pending interrupt in
// user mode at an instruction boundary, saves the return PC, switches to
// system mode and redirects fetch; on RTI restores the PC and returns to
// user mode.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : int_manager_if.slave (requests, EPC write, PC redirect, status)
//
// state  | meaning
// SYS    | system mode, kernel running, EPC writable, RTI accepted
// USER   | user mode, interrupts taken at boundaries, privileged ops fault
// E_SAVE | entry: EPC/vector captured, pipeline stalled
// E_JUMP | entry: PC loaded with vector
// R_JUMP | return: PC loaded with EPC
module int_manager #(
  parameter int VEC_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  int_manager_if.slave bus
);

  typedef enum logic [2:0] {
    SYS    = 3'd0,
    USER   = 3'd1,
    E_SAVE = 3'd2,
    E_JUMP = 3'd3,
    R_JUMP = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [VEC_W-1:0] epc_q, epc_d;
  logic [VEC_W-1:0] last_vec_q, last_vec_d;
  logic             priv_fault_q, priv_fault_d;

  logic rti_at_bnd;
  assign rti_at_bnd = bus.rti & bus.instr_boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYS;
      epc_q        <= '0;
      last_vec_q   <= '0;
      priv_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      last_vec_q   <= last_vec_d;
      priv_fault_q <= priv_fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    last_vec_d   = last_vec_q;
    priv_fault_d = 1'b0;
    unique case (state_q)
      SYS: begin
        // RTI wins over a coincident EPC write so the return uses the EPC
        // the kernel already committed.
        if (rti_at_bnd) begin
          state_d = R_JUMP;
        end else if (bus.epc_wr) begin
          epc_d = bus.epc_wdata;
        end
      end
      USER: begin
        // Faults never block a simultaneous interrupt entry.
        priv_fault_d = rti_at_bnd | bus.epc_wr;
        if (bus.manager_irq && bus.instr_boundary) begin
          state_d    = E_SAVE;
          epc_d      = bus.pc_in;
          last_vec_d = bus.int_addr;
        end
      end
      E_SAVE:  state_d = E_JUMP;
      E_JUMP:  state_d = SYS;
      R_JUMP:  state_d = USER;
      default: state_d = SYS;
    endcase
  end

  assign bus.priv_lv      = (state_q == USER);
  assign bus.cpu_stall    = (state_q == E_SAVE) || (state_q == E_JUMP) || (state_q == R_JUMP);
  assign bus.pc_load      = (state_q == E_JUMP) || (state_q == R_JUMP);
  assign bus.pc_load_addr = (state_q == E_JUMP) ? last_vec_q : epc_q;
  assign bus.epc          = epc_q;
  assign bus.last_vec     = last_vec_q;
  assign bus.priv_fault   = priv_fault_q;

endmodule

// File: tb/tb_int_manager.sv
module tb_int_manager;
  localparam int VEC_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  int_manager_if #(.VEC_W(VEC_W)) bus ();

  int_manager #(.VEC_W(VEC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.manager_irq    = 1'b0;
    bus.int_addr       = '0;
    bus.instr_boundary = 1'b0;
    bus.pc_in          = '0;
    bus.rti            = 1'b0;
    bus.epc_wr         = 1'b0;
    bus.epc_wdata      = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_priv_lv", 32'(bus.priv_lv), 0);
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    chk("rst_pc_load", 32'(bus.pc_load), 0);
    chk("rst_pc_load_addr", 32'(bus.pc_load_addr), 0);
    chk("rst_epc", 32'(bus.epc), 0);
    chk("rst_last_vec", 32'(bus.last_vec), 0);
    chk("rst_fault", 32'(bus.priv_fault), 0);
    rst_n = 1'b1;
    cyc();

    // enter user via EPC write + RTI
    bus.epc_wr = 1'b1; bus.epc_wdata = 16'h0400;
    cyc();
    bus.epc_wr = 1'b0;
    chk("sys_epc_wr", 32'(bus.epc), 32'h0400);
    chk("sys_priv_lv", 32'(bus.priv_lv), 0);
    bus.rti = 1'b1; bus.instr_boundary = 1'b1;
    cyc();
    bus.rti = 1'b0; bus.instr_boundary = 1'b0;
    chk("rj_pc_load", 32'(bus.pc_load), 1);
    chk("rj_addr", 32'(bus.pc_load_addr), 32'h0400);
    chk("rj_priv_lv", 32'(bus.priv_lv), 0);
    chk("rj_stall", 32'(bus.cpu_stall), 1);
    cyc();
    chk("user_pc_load", 32'(bus.pc_load), 0);
    chk("user_priv_lv", 32'(bus.priv_lv), 1);
    chk("user_stall", 32'(bus.cpu_stall), 0);

    // interrupt waits for boundary
    bus.pc_in = 16'h0412; bus.manager_irq = 1'b1; bus.int_addr = 16'h0014;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("irq_wait_priv", 32'(bus.priv_lv), 1);
      chk("irq_wait_stall", 32'(bus.cpu_stall), 0);
    end
    bus.instr_boundary = 1'b1;
    cyc();
    bus.instr_boundary = 1'b0;
    chk("es_priv_lv", 32'(bus.priv_lv), 0);
    chk("es_stall", 32'(bus.cpu_stall), 1);
    chk("es_pc_load", 32'(bus.pc_load), 0);
    chk("es_epc", 32'(bus.epc), 32'h0412);
    chk("es_last_vec", 32'(bus.last_vec), 32'h0014);
    cyc();
    chk("ej_pc_load", 32'(bus.pc_load), 1);
    chk("ej_addr", 32'(bus.pc_load_addr), 32'h0014);
    chk("ej_stall", 32'(bus.cpu_stall), 1);
    cyc();
    chk("sys_after_entry_stall", 32'(bus.cpu_stall), 0);
    chk("sys_after_entry_pc_load", 32'(bus.pc_load), 0);
    chk("sys_after_entry_priv", 32'(bus.priv_lv), 0);
    cyc();
    chk("irq_held_no_reentry", 32'(bus.cpu_stall), 0);
    bus.manager_irq = 1'b0;

    // RTI with coincident EPC write: write dropped
    bus.rti = 1'b1; bus.instr_boundary = 1'b1;
    bus.epc_wr = 1'b1; bus.epc_wdata = 16'hBEEF;
    cyc();
    idle_inputs();
    chk("rti_wr_drop_addr", 32'(bus.pc_load_addr), 32'h0412);
    chk("rti_wr_drop_epc", 32'(bus.epc), 32'h0412);
    cyc();
    chk("back_user", 32'(bus.priv_lv), 1);

    // privileged faults in user mode
    bus.epc_wr = 1'b1; bus.epc_wdata = 16'h1234;
    cyc();
    bus.epc_wr = 1'b0;
    chk("fault_wr_pulse", 32'(bus.priv_fault), 1);
    chk("fault_wr_epc", 32'(bus.epc), 32'h0412);
    chk("fault_wr_priv", 32'(bus.priv_lv), 1);
    cyc();
    chk("fault_wr_end", 32'(bus.priv_fault), 0);
    bus.rti = 1'b1; bus.instr_boundary = 1'b1;
    cyc();
    bus.rti = 1'b0; bus.instr_boundary = 1'b0;
    chk("fault_rti_pulse", 32'(bus.priv_fault), 1);
    chk("fault_rti_priv", 32'(bus.priv_lv), 1);
    chk("fault_rti_pc_load", 32'(bus.pc_load), 0);
    cyc();
    chk("fault_rti_end", 32'(bus.priv_fault), 0);

    // fault and interrupt together
    bus.manager_irq = 1'b1; bus.int_addr = 16'h0020; bus.pc_in = 16'h0500;
    bus.rti = 1'b1; bus.instr_boundary = 1'b1;
    cyc();
    idle_inputs();
    chk("fi_fault", 32'(bus.priv_fault), 1);
    chk("fi_stall", 32'(bus.cpu_stall), 1);
    chk("fi_epc", 32'(bus.epc), 32'h0500);
    chk("fi_last_vec", 32'(bus.last_vec), 32'h0020);
    cyc();
    chk("fi_fault_end", 32'(bus.priv_fault), 0);
    chk("fi_ej_addr", 32'(bus.pc_load_addr), 32'h0020);
    cyc();

    // back-to-back entry
    bus.epc_wr = 1'b1; bus.epc_wdata = 16'h0400;
    cyc();
    bus.epc_wr = 1'b0;
    bus.manager_irq = 1'b1; bus.int_addr = 16'h0018;
    bus.rti = 1'b1; bus.instr_boundary = 1'b1;
    cyc();
    bus.rti = 1'b0;
    chk("b2b_rj_addr", 32'(bus.pc_load_addr), 32'h0400);
    chk("b2b_rj_pc_load", 32'(bus.pc_load), 1);
    bus.pc_in = 16'h0400;
    cyc();
    bus.instr_boundary = 1'b0;
    chk("b2b_boundary_in_stall_ignored", 32'(bus.priv_lv), 1);
    bus.instr_boundary = 1'b1;
    cyc();
    bus.instr_boundary = 1'b0;
    chk("b2b_reentry_stall", 32'(bus.cpu_stall), 1);
    chk("b2b_epc", 32'(bus.epc), 32'h0400);
    chk("b2b_last_vec", 32'(bus.last_vec), 32'h0018);
    cyc(); cyc();
    bus.manager_irq = 1'b0;
    chk("b2b_sys", 32'(bus.cpu_stall), 0);

    // reset in the middle of entry
    bus.rti = 1'b1; bus.instr_boundary = 1'b1;
    cyc();
    bus.rti = 1'b0; bus.instr_boundary = 1'b0;
    cyc();
    bus.manager_irq = 1'b1; bus.int_addr = 16'h0030; bus.pc_in = 16'h0600;
    bus.instr_boundary = 1'b1;
    cyc();
    idle_inputs();
    cyc();
    chk("mid_ej_pc_load", 32'(bus.pc_load), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc_load", 32'(bus.pc_load), 0);
    chk("mid_rst_stall", 32'(bus.cpu_stall), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mid_rst_epc", 32'(bus.epc), 0);
    chk("mid_rst_last_vec", 32'(bus.last_vec), 0);
    chk("mid_rst_priv", 32'(bus.priv_lv), 0);
    chk("mid_rst_pc_load_after", 32'(bus.pc_load), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/int_manager.md
# int_manager

CPU-side responder to the interrupt controller. It accepts the pending request (`manager_irq`, `int_addr`) only while the CPU is in user mode and at an instruction boundary. On entry it saves the return PC, switches the machine to system mode and redirects fetch to the vector; on a return-from-interrupt it restores the PC and drops back to user mode. It drives `priv_lv`, which the interrupt controller uses to clear its request and acknowledge the source.

## Interface
- `VEC_W`, 16: width of PC, vector and EPC.
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `manager_irq` in 1: interrupt request level from the interrupt controller.
- `int_addr` in VEC_W: vector address; valid while `manager_irq`=1.
- `instr_boundary` in 1: CPU is between instructions; `pc_in` is the next instruction's address.
- `pc_in` in VEC_W: address of the next instruction.
- `rti` in 1: return-from-interrupt decoded; acted on only together with `instr_boundary`.
- `epc_wr` in 1: kernel write strobe for EPC.
- `epc_wdata` in VEC_W: EPC write data.
- `priv_lv` out 1: 1 = user mode (interrupts allowed), 0 = system mode.
- `cpu_stall` out 1: holds the CPU pipeline during entry/return sequences.
- `pc_load` out 1: one-cycle PC overwrite strobe.
- `pc_load_addr` out VEC_W: PC value to load when `pc_load`=1.
- `epc` out VEC_W: saved return address.
- `last_vec` out VEC_W: vector of the most recent interrupt taken.
- `priv_fault` out 1: one-cycle pulse on a privileged operation attempted in user mode.

## Operation
- States: SYS, USER, E_SAVE, E_JUMP, R_JUMP. Moore outputs decoded from the state register (glitch-free):
  - `priv_lv` = (state==USER).
  - `cpu_stall` = state in {E_SAVE, E_JUMP, R_JUMP}.
  - `pc_load` = state in {E_JUMP, R_JUMP}.
  - `pc_load_addr` = `last_vec` in E_JUMP, else `epc`.
- Reset (async): state SYS, `epc`=0, `last_vec`=0, `priv_fault`=0. The outputs then read `priv_lv`=0, `cpu_stall`=0, `pc_load`=0 and `pc_load_addr`=0.
- USER -> E_SAVE: `manager_irq`=1 and `instr_boundary`=1 at the edge. Same edge: `epc`<=`pc_in`, `last_vec`<=`int_addr`. Without a boundary the request waits indefinitely.
- E_SAVE -> E_JUMP -> SYS: unconditional, one cycle each. Inputs are ignored, except that `epc_wr` is ignored throughout.
- SYS -> R_JUMP: `rti`=1 and `instr_boundary`=1 at the edge.
- R_JUMP -> USER: unconditional, one cycle.
- SYS: `epc_wr`=1 loads `epc`<=`epc_wdata`. The kernel uses this plus `rti` to start user code.
  - If `epc_wr` and `rti`+boundary occur together, the write is dropped and the return uses the current `epc`.
- `manager_irq` is never sampled outside USER. The request the controller holds until it sees `priv_lv`=0 must not cause re-entry.
- USER privileged violations:
  - `rti`+boundary=1 or `epc_wr`=1 -> `priv_fault` pulses for 1 cycle (registered, next cycle). State and `epc` are unchanged.
  - `priv_fault` is intended to feed the segfault IRQ line.
- Fault plus interrupt in the same cycle (USER, `manager_irq`+boundary+`rti`): entry is taken and `priv_fault` still pulses.

## Timing
- Entry latency: boundary edge T -> E_SAVE during T+1 (`priv_lv`=0, `cpu_stall`=1).
  - E_JUMP during T+2: `pc_load`=1, `pc_load_addr`=vector.
  - SYS from T+3: stall released.
- Return latency: boundary edge T -> R_JUMP during T+1 (`pc_load`=1, `pc_load_addr`=`epc`, `priv_lv` still 0) -> USER from T+2.
- `pc_load` is exactly one cycle wide per transition. The CPU must not assert `instr_boundary` while `cpu_stall`=1; any such assertion is ignored.
- Back-to-back: if `manager_irq` is already 1 on entering USER, the first boundary in USER enters again. The new `epc` equals the just-restored address.
- Reset asserted mid-sequence (E_SAVE/E_JUMP/R_JUMP) immediately forces SYS. `pc_load` and `cpu_stall` drop asynchronously.

## Test plan
- Reset: `rst_n`=0 at any time -> `priv_lv`=0, `cpu_stall`=0, `pc_load`=0, `epc`=0x0000, `last_vec`=0x0000, `priv_fault`=0.
- Enter user: in SYS, `epc_wr` with 0x0400, then `rti`+boundary -> `pc_load`=1 with `pc_load_addr`=0x0400 for one cycle, then `priv_lv`=1.
- Interrupt entry: in USER, `pc_in`=0x0412, `manager_irq`=1, `int_addr`=0x0014, boundary low for 3 cycles then high.
  - No action while boundary is low.
  - After the boundary edge: `priv_lv`=0, `cpu_stall`=1.
  - Next cycle: `pc_load`=1, `pc_load_addr`=0x0014.
  - `epc`=0x0412, `last_vec`=0x0014, then SYS.
- Privileged fault: in USER, `epc_wr` with 0x1234, later `rti`+boundary -> two separate 1-cycle `priv_fault` pulses; `epc` unchanged; `priv_lv` stays 1.
- Back-to-back: `manager_irq` held at 1 (`int_addr`=0x0018) through an `rti` returning to 0x0400 -> R_JUMP, USER, first boundary re-enters; `epc`=0x0400, `last_vec`=0x0018.
- Reset mid-entry: `rst_n` low during E_JUMP -> `pc_load` and `cpu_stall` fall without a clock edge; after release, state SYS and `epc`=0.
